psum_fifo: RTL
==============

// Module: psum_fifo
// PURPOSE
//   First-word-fall-through FIFO carrying partial sums between processing elements.
//   Upstream PE writes with push_opsum/opsum_fifo_full; downstream PE reads with pop_ipsum/ipsum_fifo_empty.
//   Downstream PE samples ipsum_pixel in the same cycle it asserts pop, so the head word is always presented combinationally.
//   Adds flush, occupancy, almost-full and sticky overflow/underflow flags for array-level control.
// PARAMETERS
//   DATA_WIDTH   16  psum word width
//   DEPTH        8   number of entries; >=2, need not be a power of two
//   AFULL_LEVEL  6   almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)
// PORTS
//   clk          in   1                     clock; all state updates on rising edge
//   reset        in   1                     asynchronous, active-high reset
//   flush        in   1                     synchronous clear of contents and error flags
//   push         in   1                     write request (driven by upstream push_opsum)
//   din          in   DATA_WIDTH            write data (upstream opsum_pixel)
//   full         out  1                     count == DEPTH (to upstream opsum_fifo_full)
//   almost_full  out  1                     count >= AFULL_LEVEL
//   pop          in   1                     read request (driven by downstream pop_ipsum)
//   dout         out  DATA_WIDTH            head entry, valid while !empty (to downstream ipsum_pixel)
//   empty        out  1                     count == 0 (to downstream ipsum_fifo_empty)
//   count        out  $clog2(DEPTH+1)       current occupancy
//   overflow     out  1                     sticky: push seen while full
//   underflow    out  1                     sticky: pop seen while empty
// BEHAVIOUR
//   Reset: wr_ptr = rd_ptr = count = 0; empty=1, full=0, almost_full=0, overflow=0, underflow=0.
//     Storage array is not reset.
//   dout = mem[rd_ptr] combinationally; dout is undefined while empty, and the bench must not check it.
//   full, empty, almost_full and count are derived from registered state only. None depend on same-cycle push/pop.
//   Accept rules, evaluated on state before the edge:
//     push_ok = push & !full.
//     pop_ok  = pop & !empty.
//   push_ok: mem[wr_ptr] <= din; wr_ptr advances by 1, DEPTH-1 wraps to 0.
//   pop_ok: rd_ptr advances by 1, same wrap rule.
//   count <= count + push_ok - pop_ok.
//   Simultaneous push and pop:
//     - Neither full nor empty: both accepted, count unchanged.
//     - Full: pop accepted, push rejected, overflow set. No bypass: count drops by 1.
//     - Empty: push accepted, pop rejected, underflow set. No fall-through: count becomes 1.
//       The new word is visible on dout the next cycle.
//   Latency: a word pushed at edge N is on dout and empty=0 after edge N; it is poppable in cycle N+1.
//   Rejected push: data is dropped and storage is untouched.
//   Rejected pop: pointers are untouched.
//   overflow and underflow hold until reset or flush.
//   flush has priority over push/pop in the same cycle. It sets pointers, count and both flags to 0.
//   Asynchronous reset mid-operation: all state clears immediately. The first push after release is stored at index 0.
//   Pointer wrap for non-power-of-2 DEPTH uses an explicit compare to DEPTH-1, not bit truncation.
// TESTING
//   1. Reset, then push 0x0011,0x0022,0x0033 with no pop -> count=3, dout=0x0011, empty=0.
//      Then pop x3 -> dout 0x0022 then 0x0033, then empty=1, count=0.
//   2. DEPTH=8: push 8 words -> full=1 and almost_full=1 (asserted at count 6).
//      9th push 0xDEAD -> overflow=1, count=8, and 0xDEAD never appears on dout.
//   3. Full FIFO, push+pop in same cycle -> count=7, overflow=1, head advances.
//      Half-full FIFO, push+pop -> count unchanged, no flags.
//   4. Empty FIFO, push 0x0055 + pop in same cycle -> underflow=1, count=1, dout=0x0055 next cycle.
//   5. DEPTH=6: stream 20 words with pop every other cycle -> output order equals input order across pointer wrap.
//   6. count=5 with flags set: assert flush with push -> count=0, empty=1, flags=0.
//      Assert reset asynchronously mid-cycle -> outputs clear before the next edge.

Source files
------------

// File: rtl/psum_fifo.sv
// First-word-fall-through FIFO that carries partial sums between processing elements.
// The head word is presented combinationally; status flags come from registered state only.
module psum_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign dout        = mem_q[rd_ptr_q];

  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      if (push && full)  ovf_d = 1'b1;
      if (pop && empty)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is data only: no reset, written solely on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule
